hazard_stall_unit: RTL and testbench

//  Pipeline interlock for the 5-stage core; successor to the single-width stall logic. Sits between
//  the F/D and D/X latches: detects load-use hazards and multdiv occupancy, drives FD hold / DX bubble.

---
 rtl/hazard_stall_unit_pkg.sv | 23 ++
 rtl/hazard_stall_unit_if.sv | 27 ++
 rtl/hazard_stall_unit_ir_field_decode.sv | 64 ++++++
 rtl/hazard_stall_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared decode constants and FSM state type for the pipeline interlock.
package hazard_pkg;

   localparam int unsigned OPW       = 5;   // opcode / aluop field width
   localparam int unsigned RD_LSB    = 22;
   localparam int unsigned RS_LSB    = 17;
   localparam int unsigned RT_LSB    = 12;
   localparam int unsigned ALUOP_LSB = 2;

   localparam logic [OPW-1:0] OP_RTYPE = 5'b00000;
   localparam logic [OPW-1:0] OP_ADDI  = 5'b00101;
   localparam logic [OPW-1:0] OP_STORE = 5'b00111;
   localparam logic [OPW-1:0] OP_LOAD  = 5'b01000;

   localparam logic [OPW-1:0] ALU_MULT = 5'b00110;
   localparam logic [OPW-1:0] ALU_DIV  = 5'b00111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side signals of the interlock: F/D and D/X contents, control in, stall/status out.
interface hazard_stall_unit_if #(
   parameter int unsigned IW  = 32,
   parameter int unsigned RAW = 5
);
   logic [IW-1:0]  fd_ir;
   logic           fd_valid;
   logic [IW-1:0]  dx_ir;
   logic           dx_valid;
   logic           flush;
   logic           md_ready;
   logic           stall_fd;
   logic           bubble_dx;
   logic           md_busy;
   logic [RAW-1:0] md_dest;
   logic           md_timeout;

   modport master (
      output fd_ir, fd_valid, dx_ir, dx_valid, flush, md_ready,
      input  stall_fd, bubble_dx, md_busy, md_dest, md_timeout
   );

   modport slave (
      input  fd_ir, fd_valid, dx_ir, dx_valid, flush, md_ready,
      output stall_fd, bubble_dx, md_busy, md_dest, md_timeout
   );
endinterface

// File: rtl/hazard_stall_unit_ir_field_decode.sv
// Per-instruction field decode: instruction class plus source/destination registers.
// A register field of 0 never reports as valid, so r0 cannot create a hazard.
module ir_field_decode
   import hazard_pkg::*;
#(
   parameter int unsigned IW  = 32,
   parameter int unsigned RAW = 5
) (
   input  logic [IW-1:0]  ir,
   output logic           is_load,
   output logic           is_store,
   output logic           is_md,
   output logic [RAW-1:0] src_a,
   output logic           src_a_vld,
   output logic [RAW-1:0] src_b,
   output logic           src_b_vld,
   output logic [RAW-1:0] dst,
   output logic           dst_vld
);

   logic [OPW-1:0] op;
   logic [OPW-1:0] aluop;
   logic [RAW-1:0] rd;
   logic [RAW-1:0] rs;
   logic [RAW-1:0] rt;
   logic           is_rtype;
   logic           is_addi;
   logic           unused_bits;

   // Extract fields and classify the instruction
   always_comb begin
      op        = ir[IW-1 -: OPW];
      aluop     = ir[ALUOP_LSB +: OPW];
      rd        = ir[RD_LSB +: RAW];
      rs        = ir[RS_LSB +: RAW];
      rt        = ir[RT_LSB +: RAW];

      is_rtype  = (op == OP_RTYPE);
      is_addi   = (op == OP_ADDI);
      is_load   = (op == OP_LOAD);
      is_store  = (op == OP_STORE);
      is_md     = is_rtype & ((aluop == ALU_MULT) | (aluop == ALU_DIV));

      src_a     = rs;
      src_a_vld = (rs != '0);

      // Stores read their data register through the rd field
      src_b     = '0;
      src_b_vld = 1'b0;
      if (is_rtype) begin
         src_b     = rt;
         src_b_vld = (rt != '0);
      end else if (is_store) begin
         src_b     = rd;
         src_b_vld = (rd != '0);
      end

      dst       = rd;
      dst_vld   = (is_rtype | is_addi | is_load) & (rd != '0);
   end

   assign unused_bits = ^{ir[ALUOP_LSB-1:0], ir[RT_LSB-1:ALUOP_LSB+OPW]};

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock between F/D and D/X: load-use stall, multdiv scoreboard
// (only dependents of the in-flight multdiv stall), flush masking and a multdiv watchdog.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned IW         = 32,
   parameter int unsigned RAW        = 5,
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned STRICT_MD  = 0
) (
   input  logic                clock,
   input  logic                global_reset,
   hazard_stall_unit_if.slave  bus
);

   localparam int unsigned    CW       = $clog2(MD_TIMEOUT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MD_TIMEOUT - 1);

   logic           fd_is_load, fd_is_store, fd_is_md;
   logic [RAW-1:0] fd_src_a, fd_src_b, fd_dst;
   logic           fd_src_a_vld, fd_src_b_vld, fd_dst_vld;
   logic           dx_is_load, dx_is_store, dx_is_md;
   logic [RAW-1:0] dx_src_a, dx_src_b, dx_dst;
   logic           dx_src_a_vld, dx_src_b_vld, dx_dst_vld;
   logic           unused_dec;

   md_state_t      state_q, state_d;
   logic [RAW-1:0] dest_q, dest_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           tmo_q, tmo_d;

   logic           load_use;
   logic           md_issue;
   logic           issue_dep;
   logic           busy_dep;
   logic           stall;

   ir_field_decode #(.IW(IW), .RAW(RAW)) u_fd_dec (
      .ir        (bus.fd_ir),
      .is_load   (fd_is_load),
      .is_store  (fd_is_store),
      .is_md     (fd_is_md),
      .src_a     (fd_src_a),
      .src_a_vld (fd_src_a_vld),
      .src_b     (fd_src_b),
      .src_b_vld (fd_src_b_vld),
      .dst       (fd_dst),
      .dst_vld   (fd_dst_vld)
   );

   ir_field_decode #(.IW(IW), .RAW(RAW)) u_dx_dec (
      .ir        (bus.dx_ir),
      .is_load   (dx_is_load),
      .is_store  (dx_is_store),
      .is_md     (dx_is_md),
      .src_a     (dx_src_a),
      .src_a_vld (dx_src_a_vld),
      .src_b     (dx_src_b),
      .src_b_vld (dx_src_b_vld),
      .dst       (dx_dst),
      .dst_vld   (dx_dst_vld)
   );

   assign unused_dec = ^{fd_is_load, fd_is_store, dx_is_store,
                         dx_src_a, dx_src_a_vld, dx_src_b, dx_src_b_vld};

   // Multdiv FSM, scoreboard destination, watchdog counter and timeout pulse
   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         state_q <= IDLE;
         dest_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // Hazard terms, stall and multdiv next state
   always_comb begin
      load_use  = bus.dx_valid & dx_is_load & dx_dst_vld & bus.fd_valid &
                  ((fd_src_a_vld & (fd_src_a == dx_dst)) |
                   (fd_src_b_vld & (fd_src_b == dx_dst)));

      md_issue  = bus.dx_valid & dx_is_md & ~bus.flush;

      issue_dep = md_issue & bus.fd_valid &
                  (fd_is_md |
                   (dx_dst_vld & ((fd_src_a_vld & (fd_src_a == dx_dst)) |
                                  (fd_src_b_vld & (fd_src_b == dx_dst)) |
                                  (fd_dst_vld   & (fd_dst   == dx_dst)))));

      // The writeback cycle (md_ready) bypasses, so the scoreboard term drops then
      busy_dep  = (state_q == BUSY) & ~bus.md_ready & bus.fd_valid &
                  ((STRICT_MD != 0) ? 1'b1 :
                   (fd_is_md |
                    ((dest_q != '0) & ((fd_src_a_vld & (fd_src_a == dest_q)) |
                                       (fd_src_b_vld & (fd_src_b == dest_q)) |
                                       (fd_dst_vld   & (fd_dst   == dest_q))))));

      // issue_dep already carries the flush mask through md_issue
      stall     = ~global_reset & ((load_use & ~bus.flush) | issue_dep | busy_dep);

      state_d   = state_q;
      dest_d    = dest_q;
      cnt_d     = cnt_q;
      tmo_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (md_issue) begin
               state_d = BUSY;
               dest_d  = dx_dst;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (md_issue) begin
               dest_d  = dx_dst;
               cnt_d   = '0;
            end else if (bus.md_ready) begin
               state_d = IDLE;
               dest_d  = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               dest_d  = '0;
               cnt_d   = '0;
               tmo_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            dest_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.stall_fd   = stall;
   assign bus.bubble_dx  = stall;
   assign bus.md_busy    = (state_q == BUSY);
   assign bus.md_dest    = dest_q;
   assign bus.md_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: three instances (scoreboard/64, strict/64,
// scoreboard/8) see identical stimulus; expectations are hand-derived per step.
module tb_hazard_stall_unit;

   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_STORE = 5'b00111;
   localparam logic [4:0] OP_LOAD  = 5'b01000;
   localparam logic [4:0] A_ADD    = 5'b00000;
   localparam logic [4:0] A_MULT   = 5'b00110;
   localparam logic [4:0] A_DIV    = 5'b00111;

   logic        clock;
   logic        global_reset;
   logic [31:0] fd_ir;
   logic        fd_valid;
   logic [31:0] dx_ir;
   logic        dx_valid;
   logic        flush;
   logic        md_ready;

   int checks   = 0;
   int failures = 0;

   hazard_stall_unit_if #(.IW(32), .RAW(5)) b0 ();
   hazard_stall_unit_if #(.IW(32), .RAW(5)) b1 ();
   hazard_stall_unit_if #(.IW(32), .RAW(5)) b2 ();

   assign b0.fd_ir = fd_ir;  assign b0.fd_valid = fd_valid;  assign b0.dx_ir = dx_ir;
   assign b0.dx_valid = dx_valid;  assign b0.flush = flush;  assign b0.md_ready = md_ready;
   assign b1.fd_ir = fd_ir;  assign b1.fd_valid = fd_valid;  assign b1.dx_ir = dx_ir;
   assign b1.dx_valid = dx_valid;  assign b1.flush = flush;  assign b1.md_ready = md_ready;
   assign b2.fd_ir = fd_ir;  assign b2.fd_valid = fd_valid;  assign b2.dx_ir = dx_ir;
   assign b2.dx_valid = dx_valid;  assign b2.flush = flush;  assign b2.md_ready = md_ready;

   hazard_stall_unit #(.IW(32), .RAW(5), .MD_TIMEOUT(64), .STRICT_MD(0)) u0 (
      .clock(clock), .global_reset(global_reset), .bus(b0));
   hazard_stall_unit #(.IW(32), .RAW(5), .MD_TIMEOUT(64), .STRICT_MD(1)) u1 (
      .clock(clock), .global_reset(global_reset), .bus(b1));
   hazard_stall_unit #(.IW(32), .RAW(5), .MD_TIMEOUT(8), .STRICT_MD(0)) u2 (
      .clock(clock), .global_reset(global_reset), .bus(b2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] aluop);
      return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
   endfunction

   function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs);
      return {op, rd, rs, 17'd0};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      global_reset = 1'b1;
      fd_ir = '0;  fd_valid = 1'b0;  dx_ir = '0;  dx_valid = 1'b0;
      flush = 1'b0;  md_ready = 1'b0;

      // reset state
      #2;
      chk1("rst_busy", b0.md_busy, 1'b0);
      chk5("rst_dest", b0.md_dest, 5'd0);
      chk1("rst_tmo", b0.md_timeout, 1'b0);
      chk1("rst_stall", b0.stall_fd, 1'b0);
      #10 global_reset = 1'b0;

      // 1: lw r3 / add r4,r3,r5 -> one stall cycle, then bubble in DX
      tick();
      dx_ir = i_ins(OP_LOAD, 5'd3, 5'd1);  dx_valid = 1'b1;
      fd_ir = r_ins(5'd4, 5'd3, 5'd5, A_ADD);  fd_valid = 1'b1;
      #1;
      chk1("lu_stall", b0.stall_fd, 1'b1);
      chk1("lu_bubble", b0.bubble_dx, 1'b1);
      tick();
      dx_valid = 1'b0;
      #1;
      chk1("lu_release", b0.stall_fd, 1'b0);
      chk1("lu_release_bub", b0.bubble_dx, 1'b0);
      chk1("lu_no_busy", b0.md_busy, 1'b0);
      dx_valid = 1'b1;  fd_valid = 1'b0;
      #1;
      chk1("lu_fd_bubble", b0.stall_fd, 1'b0);

      // 2: store data dependence, addi source, WAW-only, r0 load
      tick();
      dx_ir = i_ins(OP_LOAD, 5'd3, 5'd1);  dx_valid = 1'b1;
      fd_ir = i_ins(OP_STORE, 5'd3, 5'd7);  fd_valid = 1'b1;
      #1;
      chk1("lu_store_data", b0.stall_fd, 1'b1);
      fd_ir = i_ins(OP_ADDI, 5'd4, 5'd3);
      #1;
      chk1("lu_addi_src", b0.stall_fd, 1'b1);
      fd_ir = i_ins(OP_ADDI, 5'd3, 5'd1);
      #1;
      chk1("lu_waw_only", b0.stall_fd, 1'b0);
      dx_ir = i_ins(OP_LOAD, 5'd0, 5'd1);
      fd_ir = i_ins(OP_STORE, 5'd0, 5'd7);
      #1;
      chk1("lu_r0", b0.stall_fd, 1'b0);

      // 3: scoreboard vs strict mode
      tick();
      dx_ir = r_ins(5'd6, 5'd1, 5'd2, A_MULT);  dx_valid = 1'b1;
      fd_ir = r_ins(5'd10, 5'd1, 5'd2, A_ADD);  fd_valid = 1'b1;
      #1;
      chk1("iss_indep", b0.stall_fd, 1'b0);
      chk1("iss_indep_strict", b1.stall_fd, 1'b0);
      chk1("iss_not_busy_yet", b0.md_busy, 1'b0);
      tick();
      dx_ir = r_ins(5'd10, 5'd1, 5'd2, A_ADD);
      fd_ir = r_ins(5'd11, 5'd1, 5'd2, A_ADD);
      #1;
      chk1("busy_set", b0.md_busy, 1'b1);
      chk5("busy_dest", b0.md_dest, 5'd6);
      chk1("busy_indep", b0.stall_fd, 1'b0);
      chk1("busy_indep_strict", b1.stall_fd, 1'b1);
      tick();
      dx_ir = r_ins(5'd11, 5'd1, 5'd2, A_ADD);
      fd_ir = r_ins(5'd9, 5'd6, 5'd1, A_ADD);
      #1;
      chk1("busy_dep_raw", b0.stall_fd, 1'b1);
      fd_ir = i_ins(OP_ADDI, 5'd6, 5'd1);
      #1;
      chk1("busy_dep_waw", b0.stall_fd, 1'b1);
      tick();
      dx_valid = 1'b0;
      fd_ir = r_ins(5'd12, 5'd1, 5'd2, A_MULT);
      #1;
      chk1("busy_fd_md", b0.stall_fd, 1'b1);
      tick();
      fd_ir = r_ins(5'd9, 5'd6, 5'd1, A_ADD);
      md_ready = 1'b1;
      #1;
      chk1("rdy_bypass", b0.stall_fd, 1'b0);
      chk1("rdy_bypass_strict", b1.stall_fd, 1'b0);
      chk1("rdy_still_busy", b0.md_busy, 1'b1);
      tick();
      md_ready = 1'b0;
      #1;
      chk1("rdy_idle", b0.md_busy, 1'b0);
      chk1("rdy_idle_strict", b1.md_busy, 1'b0);
      chk1("rdy_no_stall", b0.stall_fd, 1'b0);

      // 4: md_ready with back-to-back div issue; 5: watchdog on the 8-cycle instance
      tick();
      dx_ir = r_ins(5'd6, 5'd1, 5'd2, A_MULT);  dx_valid = 1'b1;  fd_valid = 1'b0;
      #1;
      chk1("b2b_idle", b0.md_busy, 1'b0);
      tick();
      dx_valid = 1'b0;
      #1;
      chk1("b2b_busy", b0.md_busy, 1'b1);
      chk5("b2b_dest6", b0.md_dest, 5'd6);
      tick();
      tick();
      md_ready = 1'b1;
      dx_ir = r_ins(5'd7, 5'd1, 5'd2, A_DIV);  dx_valid = 1'b1;
      #1;
      chk1("b2b_rdy_busy", b0.md_busy, 1'b1);
      tick();
      md_ready = 1'b0;  dx_valid = 1'b0;
      #1;
      chk1("b2b_stay_busy", b0.md_busy, 1'b1);
      chk5("b2b_dest7", b0.md_dest, 5'd7);
      chk5("b2b_dest7_t8", b2.md_dest, 5'd7);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk1("wd_early", b2.md_timeout, 1'b0);
         chk1("wd_busy", b2.md_busy, 1'b1);
      end
      tick();
      chk1("wd_pulse", b2.md_timeout, 1'b1);
      chk1("wd_idle", b2.md_busy, 1'b0);
      chk5("wd_dest0", b2.md_dest, 5'd0);
      chk1("wd_long_busy", b0.md_busy, 1'b1);
      chk1("wd_long_notmo", b0.md_timeout, 1'b0);
      tick();
      chk1("wd_pulse_end", b2.md_timeout, 1'b0);
      md_ready = 1'b1;
      tick();
      md_ready = 1'b0;
      #1;
      chk1("rdy_done_u0", b0.md_busy, 1'b0);
      chk1("rdy_ignored_idle", b2.md_busy, 1'b0);
      chk1("rdy_ignored_tmo", b2.md_timeout, 1'b0);

      // 6: flush masking, flush during BUSY, reset mid-BUSY
      tick();
      dx_ir = i_ins(OP_LOAD, 5'd3, 5'd1);  dx_valid = 1'b1;
      fd_ir = r_ins(5'd4, 5'd3, 5'd5, A_ADD);  fd_valid = 1'b1;  flush = 1'b1;
      #1;
      chk1("fl_loaduse", b0.stall_fd, 1'b0);
      dx_ir = r_ins(5'd6, 5'd1, 5'd2, A_MULT);
      fd_ir = r_ins(5'd9, 5'd6, 5'd1, A_ADD);
      #1;
      chk1("fl_issue", b0.stall_fd, 1'b0);
      tick();
      flush = 1'b0;  dx_valid = 1'b0;  fd_valid = 1'b0;
      #1;
      chk1("fl_no_busy", b0.md_busy, 1'b0);
      dx_valid = 1'b1;  fd_valid = 1'b1;
      #1;
      chk1("iss_dep", b0.stall_fd, 1'b1);
      tick();
      dx_valid = 1'b0;  flush = 1'b1;
      #1;
      chk1("fl_busy_dep", b0.stall_fd, 1'b1);
      chk1("fl_busy_kept", b0.md_busy, 1'b1);
      #1;
      flush = 1'b0;
      global_reset = 1'b1;
      #1;
      chk1("rst_mid_busy", b0.md_busy, 1'b0);
      chk5("rst_mid_dest", b0.md_dest, 5'd0);
      chk1("rst_mid_stall", b0.stall_fd, 1'b0);
      #2 global_reset = 1'b0;
      tick();
      md_ready = 1'b1;
      #1;
      chk1("post_rst_stall", b0.stall_fd, 1'b0);
      tick();
      md_ready = 1'b0;
      #1;
      chk1("post_rst_idle", b0.md_busy, 1'b0);
      chk1("post_rst_tmo", b0.md_timeout, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
